// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register-file write port between WB and a long-latency unit
module regfile_wb_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipe_we,
    input  logic [4:0]  pipe_rd,
    input  logic [31:0] pipe_data,
    input  logic        lu_valid,
    input  logic [4:0]  lu_rd,
    input  logic [31:0] lu_data,
    output logic        lu_ready,
    input  logic        mark_valid,
    input  logic [4:0]  mark_rd,
    input  logic        dec_valid,
    input  logic [4:0]  dec_rs1,
    input  logic [4:0]  dec_rs2,
    input  logic [4:0]  dec_rd,
    output logic        stall,
    output logic        pipe_hold,
    output logic        rf_we,
    output logic [4:0]  rf_rd,
    output logic [31:0] rf_wdata
);
    localparam int AW = $clog2(DEPTH);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [AW:0]   FULL  = DEPTH[AW:0];
    localparam logic [SW-1:0] LIMIT = STARVE_LIMIT[SW-1:0];

    logic [4:0]    q_rd   [DEPTH];
    logic [31:0]   q_data [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   count;
    logic [SW-1:0] starve;
    logic [31:0]   busy, busy_nx;
    logic          src_lu, pipe_sel, pop, push;

    assign lu_ready  = count < FULL;
    assign pipe_sel  = pipe_we && pipe_rd != 5'd0;
    assign pop       = !pipe_sel && count != '0;
    assign push      = lu_valid && lu_ready && lu_rd != 5'd0;
    assign stall     = dec_valid && (busy[dec_rs1] || busy[dec_rs2] || busy[dec_rd]);
    assign pipe_hold = starve == LIMIT;

    // FIFO storage needs no reset; the pointers define what is valid
    always_ff @(posedge clk) begin
        if (push) begin
            q_rd[wptr]   <= lu_rd;
            q_data[wptr] <= lu_data;
        end
    end

    // FIFO pointers and occupancy; push and pop together leave count unchanged
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            wptr  <= push ? wptr + AW'(1) : wptr;
            rptr  <= pop ? rptr + AW'(1) : rptr;
            count <= (push && !pop) ? count + 1'b1 : (!push && pop) ? count - 1'b1 : count;
        end
    end

    // Scoreboard update: clear on committed long-unit write, then set so a new mark wins
    always_comb begin
        busy_nx = busy;
        if (rf_we && src_lu) busy_nx[rf_rd] = 1'b0;
        if (mark_valid) busy_nx[mark_rd] = 1'b1;
        busy_nx[0] = 1'b0;
    end

    // Scoreboard register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) busy <= '0;
        else busy <= busy_nx;
    end

    // Starvation counter: counts cycles with buffered results but no pop, saturating
    always_ff @(posedge clk or posedge rst) begin
        if (rst) starve <= '0;
        else if (count == '0 || pop) starve <= '0;
        else if (starve != LIMIT) starve <= starve + 1'b1;
    end

    // Registered write port; address/data hold when no write is selected
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we    <= 1'b0;
            src_lu   <= 1'b0;
            rf_rd    <= '0;
            rf_wdata <= '0;
        end else begin
            rf_we  <= pipe_sel || pop;
            src_lu <= pop;
            if (pipe_sel) begin
                rf_rd    <= pipe_rd;
                rf_wdata <= pipe_data;
            end else if (pop) begin
                rf_rd    <= q_rd[rptr];
                rf_wdata <= q_data[rptr];
            end
        end
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed and random checks against a queue-based reference model
module tb_regfile_wb_arbiter;
    localparam int DEPTH = 4;
    localparam int LIMIT = 8;

    logic        clk = 1'b0, rst = 1'b1;
    logic        pipe_we = 0, lu_valid = 0, mark_valid = 0, dec_valid = 0;
    logic [4:0]  pipe_rd = 0, lu_rd = 0, mark_rd = 0, dec_rs1 = 0, dec_rs2 = 0, dec_rd = 0;
    logic [31:0] pipe_data = 0, lu_data = 0;
    logic        lu_ready, stall, pipe_hold, rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wdata;

    regfile_wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .pipe_we(pipe_we), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
        .lu_valid(lu_valid), .lu_rd(lu_rd), .lu_data(lu_data), .lu_ready(lu_ready),
        .mark_valid(mark_valid), .mark_rd(mark_rd),
        .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
        .stall(stall), .pipe_hold(pipe_hold),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    int          checks = 0, failures = 0;
    ent_t        q[$];
    bit          busy_m[32];
    int          starve_m;
    bit          ew, esrc;
    logic [4:0]  erd;
    logic [31:0] edata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        foreach (busy_m[i]) busy_m[i] = 0;
        starve_m = 0;
        ew = 0; esrc = 0; erd = 0; edata = 0;
    endtask

    task automatic drive(input bit pw, input int prd, input int pdat,
                         input bit lv, input int lrd, input int ldat,
                         input bit mv, input int mrd);
        pipe_we = pw; pipe_rd = 5'(prd); pipe_data = 32'(pdat);
        lu_valid = lv; lu_rd = 5'(lrd); lu_data = 32'(ldat);
        mark_valid = mv; mark_rd = 5'(mrd);
    endtask

    task automatic set_dec(input bit v, input int a, input int b, input int d);
        dec_valid = v; dec_rs1 = 5'(a); dec_rs2 = 5'(b); dec_rd = 5'(d);
    endtask

    // One clock: check combinational outputs, advance the model, check registered outputs
    task automatic step(input string tag);
        bit   pipe, pop, push, rdy, st;
        ent_t e;
        #2;
        rdy = q.size() < DEPTH;
        st  = dec_valid && ((dec_rs1 != 0 && busy_m[dec_rs1]) ||
                            (dec_rs2 != 0 && busy_m[dec_rs2]) ||
                            (dec_rd  != 0 && busy_m[dec_rd]));
        chk({tag, ".lu_ready"}, lu_ready, rdy);
        chk({tag, ".stall"}, stall, st);
        chk({tag, ".pipe_hold"}, pipe_hold, starve_m == LIMIT);
        pipe = pipe_we && pipe_rd != 0;
        pop  = !pipe && q.size() > 0;
        push = lu_valid && rdy && lu_rd != 0;
        if (ew && esrc) busy_m[erd] = 0;
        if (mark_valid && mark_rd != 0) busy_m[mark_rd] = 1;
        starve_m = (q.size() == 0 || pop) ? 0 : (starve_m < LIMIT ? starve_m + 1 : LIMIT);
        ew = pipe || pop;
        esrc = pop;
        if (pipe) begin
            erd = pipe_rd; edata = pipe_data;
        end else if (pop) begin
            e = q.pop_front(); erd = e.rd; edata = e.data;
        end
        if (push) begin
            e.rd = lu_rd; e.data = lu_data; q.push_back(e);
        end
        @(posedge clk);
        #1;
        chk({tag, ".rf_we"}, rf_we, ew);
        if (ew) begin
            chk({tag, ".rf_rd"}, rf_rd, erd);
            chk({tag, ".rf_wdata"}, rf_wdata, edata);
        end
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 0;

        // Idle after reset
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        step("idle");
        chk("idle.rf_we0", rf_we, 0);
        chk("idle.ready1", lu_ready, 1);

        // Scoreboard mark, stall, long-unit return and clear
        drive(0, 0, 0, 0, 0, 0, 1, 7);
        step("mark7");
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        set_dec(1, 7, 0, 0);
        #2 chk("raw.stall", stall, 1);
        step("raw");
        drive(0, 0, 0, 1, 7, 32'hDEADBEEF, 0, 0);
        step("push7");
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        step("wr7");
        chk("wr7.we", rf_we, 1);
        chk("wr7.rd", rf_rd, 7);
        chk("wr7.data", rf_wdata, 32'hDEADBEEF);
        step("clr7");
        chk("clr7.stall", stall, 0);
        set_dec(0, 0, 0, 0);

        // Pipe write beats a buffered result
        drive(0, 0, 0, 1, 9, 32'h99, 0, 0);
        step("push9");
        drive(1, 3, 32'h11, 0, 0, 0, 0, 0);
        step("pipe3");
        chk("pipe3.rd", rf_rd, 3);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        step("drain9");
        chk("drain9.rd", rf_rd, 9);

        // Fill FIFO under continuous pipe writes, starve, then drain in order
        for (int i = 0; i < 10; i++) begin
            drive(1, 1 + i, 32'h100 + i, i < 4, 20 + i, 32'h200 + i, 0, 0);
            step("fill");
        end
        chk("fill.ready0", lu_ready, 0);
        chk("fill.hold", pipe_hold, 1);
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0);
            step("drain");
            chk("drain.rd", rf_rd, 20 + i);
            chk("drain.hold0", pipe_hold, 0);
        end

        // Register 0 on both sources is ignored
        drive(1, 0, 32'h55, 1, 0, 32'h66, 1, 0);
        step("zero");
        chk("zero.we", rf_we, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        step("zero2");
        chk("zero2.we", rf_we, 0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 2) != 0) && !(pipe_hold && $urandom_range(0, 1) != 0),
                  $urandom_range(0, 7), $urandom,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 7), $urandom,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 7));
            set_dec($urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
            step("rand");
        end

        // Asynchronous reset with pending entries and a busy register
        set_dec(0, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0);
            step("pre");
        end
        drive(1, 1, 32'h1, 1, 11, 32'hA, 1, 5);
        step("r0");
        drive(1, 2, 32'h2, 1, 12, 32'hB, 0, 0);
        step("r1");
        drive(1, 3, 32'h3, 1, 13, 32'hC, 0, 0);
        step("r2");
        set_dec(1, 5, 0, 0);
        #2 chk("r.stall_pre", stall, 1);
        rst = 1;
        #1;
        chk("rst.we", rf_we, 0);
        chk("rst.rd", rf_rd, 0);
        chk("rst.data", rf_wdata, 0);
        chk("rst.stall", stall, 0);
        chk("rst.hold", pipe_hold, 0);
        chk("rst.ready", lu_ready, 1);
        model_reset();
        @(posedge clk);
        #1 rst = 0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step("post");
            chk("post.we", rf_we, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
